// File: rtl/ltl_report_collector_if.sv
// Report stream from the collector to the monitor aggregator: valid/ready with {timestamp, report_mask}.
interface ltl_report_collector_if #(
  parameter int NUM_REPORTS = 4,
  parameter int TS_WIDTH    = 32
);
  logic                            rpt_valid;
  logic                            rpt_ready;
  logic [TS_WIDTH+NUM_REPORTS-1:0] rpt_data;

  modport master (output rpt_valid, output rpt_data, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_data, output rpt_ready);
endinterface

// File: rtl/ltl_report_collector.sv
// Tags non-zero report vectors with the triggering symbol index and queues them; 2-cycle run-to-valid latency.
// A full FIFO drops new events unless a pop frees the slot in the same cycle; drops are counted and flagged.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      run,
  input  logic [NUM_REPORTS-1:0]    report_in,
  ltl_report_collector_if.master    rpt,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  output logic [CNT_WIDTH-1:0]      drop_count,
  output logic                      any_report
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_WIDTH + NUM_REPORTS;

  logic [TS_WIDTH-1:0] sym_idx;
  logic                run_q;
  logic [TS_WIDTH-1:0] ts_q;

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [DW-1:0]       mem [DEPTH];

  logic                fifo_empty;
  logic                fifo_full;
  logic                evt;
  logic                pop;
  logic                push;
  logic                drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // report_in lags run by one cycle, so qualify it with the registered run.
  assign evt  = run_q && (report_in != '0) && !clear;
  assign pop  = !fifo_empty && rpt.rpt_ready && !clear;
  assign push = evt && (!fifo_full || pop);
  assign drop = evt && fifo_full && !pop;

  assign rpt.rpt_valid = !fifo_empty;
  assign rpt.rpt_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign fifo_level    = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_idx <= '0;
      run_q   <= 1'b0;
      ts_q    <= '0;
    end else if (clear) begin
      sym_idx <= '0;
      run_q   <= 1'b0;
      ts_q    <= '0;
    end else begin
      run_q <= run;
      ts_q  <= sym_idx;
      if (run)
        sym_idx <= sym_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, the write slot equals the head slot; the head is read out combinationally before this edge.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {ts_q, report_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      any_report <= 1'b0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      any_report <= 1'b0;
    end else begin
      if (evt)
        any_report <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed bench: a default instance plus a narrow one (TS_WIDTH=4, CNT_WIDTH=2) for wrap and saturation.
module tb_ltl_report_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        run;
  logic [3:0]  report_in;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        any_report;

  logic        s_clear;
  logic        s_run;
  logic [3:0]  s_report_in;
  logic [3:0]  s_level;
  logic        s_overflow;
  logic [1:0]  s_drop;
  logic        s_any;

  int errors = 0;
  int checks = 0;

  ltl_report_collector_if #(.NUM_REPORTS(4), .TS_WIDTH(32)) rpt_if ();
  ltl_report_collector_if #(.NUM_REPORTS(4), .TS_WIDTH(4))  s_if ();

  ltl_report_collector #(.NUM_REPORTS(4), .DEPTH(8), .TS_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .run        (run),
    .report_in  (report_in),
    .rpt        (rpt_if.master),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .any_report (any_report)
  );

  ltl_report_collector #(.NUM_REPORTS(4), .DEPTH(8), .TS_WIDTH(4), .CNT_WIDTH(2)) u_small (
    .clk        (clk),
    .reset      (reset),
    .clear      (s_clear),
    .run        (s_run),
    .report_in  (s_report_in),
    .rpt        (s_if.master),
    .fifo_level (s_level),
    .overflow   (s_overflow),
    .drop_count (s_drop),
    .any_report (s_any)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; run = 1'b0; report_in = 4'h0; rpt_if.rpt_ready = 1'b0;
    s_clear = 1'b0; s_run = 1'b0; s_report_in = 4'h0; s_if.rpt_ready = 1'b0;
    tick();
    tick();
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rpt_if.rpt_valid); end
    checks++; if (rpt_if.rpt_data !== 36'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rpt_if.rpt_data); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if ({overflow, drop_count, any_report} !== 18'h0) begin errors++; $display("FAIL reset_flags: ovf=%b drop=%0d any=%b want 0", overflow, drop_count, any_report); end
    checks++; if ({s_if.rpt_valid, s_level, s_overflow, s_drop, s_any} !== 9'h0) begin errors++; $display("FAIL reset_small: valid=%b level=%0d ovf=%b drop=%0d any=%b want 0", s_if.rpt_valid, s_level, s_overflow, s_drop, s_any); end
    reset = 1'b0;
  endtask

  task automatic test_single_event();
    for (int i = 0; i < 6; i++) begin
      run = 1'b1;
      report_in = (i == 4) ? 4'b0010 : 4'b0000;
      tick();
      checks++; if (rpt_if.rpt_valid !== (i >= 4)) begin errors++; $display("FAIL single_valid_c%0d: got %b want %b", i, rpt_if.rpt_valid, (i >= 4)); end
    end
    run = 1'b0; report_in = 4'h0;
    tick();
    checks++; if (rpt_if.rpt_data !== {32'd3, 4'b0010}) begin errors++; $display("FAIL single_data: got %h want %h", rpt_if.rpt_data, {32'd3, 4'b0010}); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    checks++; if (any_report !== 1'b1) begin errors++; $display("FAIL single_any: got %b want 1", any_report); end
    rpt_if.rpt_ready = 1'b1;
    tick();
    rpt_if.rpt_ready = 1'b0;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", fifo_level); end
    checks++; if ({rpt_if.rpt_valid, rpt_if.rpt_data} !== 37'h0) begin errors++; $display("FAIL single_empty: valid=%b data=%h want 0", rpt_if.rpt_valid, rpt_if.rpt_data); end
  endtask

  task automatic test_gap();
    logic [4:0] run_seq;
    run_seq = 5'b00101;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (any_report !== 1'b0) begin errors++; $display("FAIL gap_clear_any: got %b want 0", any_report); end
    report_in = 4'hF;
    for (int i = 0; i < 5; i++) begin
      run = run_seq[i];
      tick();
    end
    run = 1'b0;
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL gap_level: got %0d want 2", fifo_level); end
    report_in = 4'h0;
    rpt_if.rpt_ready = 1'b1;
    checks++; if (rpt_if.rpt_data !== {32'd0, 4'hF}) begin errors++; $display("FAIL gap_entry0: got %h want %h", rpt_if.rpt_data, {32'd0, 4'hF}); end
    tick();
    checks++; if (rpt_if.rpt_data !== {32'd1, 4'hF}) begin errors++; $display("FAIL gap_entry1: got %h want %h", rpt_if.rpt_data, {32'd1, 4'hF}); end
    tick();
    rpt_if.rpt_ready = 1'b0;
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL gap_drained: got %b want 0", rpt_if.rpt_valid); end
  endtask

  task automatic test_overflow();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rpt_if.rpt_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      run = (i < 10);
      report_in = (i >= 1) ? 4'h1 : 4'h0;
      tick();
    end
    report_in = 4'h0;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drops: got %0d want 2", drop_count); end
    checks++; if (rpt_if.rpt_data !== {32'd0, 4'h1}) begin errors++; $display("FAIL ovf_head_hold: got %h want %h", rpt_if.rpt_data, {32'd0, 4'h1}); end
  endtask

  task automatic test_full_push_pop();
    logic [35:0] exp;
    run = 1'b1; report_in = 4'h0;
    tick();
    run = 1'b0; report_in = 4'h3; rpt_if.rpt_ready = 1'b1;
    checks++; if (rpt_if.rpt_data !== {32'd0, 4'h1}) begin errors++; $display("FAIL fpp_head: got %h want %h", rpt_if.rpt_data, {32'd0, 4'h1}); end
    tick();
    report_in = 4'h0;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fpp_level: got %0d want 8", fifo_level); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL fpp_no_drop: got %0d want 2", drop_count); end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? {32'(k + 1), 4'h1} : {32'd10, 4'h3};
      checks++; if (rpt_if.rpt_data !== exp) begin errors++; $display("FAIL fpp_drain%0d: got %h want %h", k, rpt_if.rpt_data, exp); end
      tick();
    end
    rpt_if.rpt_ready = 1'b0;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL fpp_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_wrap_saturation();
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    for (int i = 0; i < 19; i++) begin
      s_run = (i < 18);
      s_report_in = (i == 18) ? 4'h8 : 4'h0;
      tick();
    end
    s_report_in = 4'h0;
    checks++; if (s_level !== 4'd1) begin errors++; $display("FAIL wrap_level: got %0d want 1", s_level); end
    checks++; if (s_if.rpt_data !== {4'd1, 4'h8}) begin errors++; $display("FAIL wrap_ts: got %h want %h", s_if.rpt_data, {4'd1, 4'h8}); end
    for (int i = 0; i < 13; i++) begin
      s_run = 1'b1;
      s_report_in = (i >= 1) ? 4'h1 : 4'h0;
      tick();
    end
    s_run = 1'b0; s_report_in = 4'h0;
    checks++; if (s_level !== 4'd8) begin errors++; $display("FAIL sat_level: got %0d want 8", s_level); end
    checks++; if (s_drop !== 2'd3) begin errors++; $display("FAIL sat_drops: got %0d want 3", s_drop); end
    checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", s_overflow); end
  endtask

  task automatic queue_three();
    for (int i = 0; i < 4; i++) begin
      run = 1'b1;
      report_in = (i >= 1) ? 4'h2 : 4'h0;
      tick();
    end
  endtask

  task automatic check_restart(input string tag);
    run = 1'b1; report_in = 4'h0;
    tick();
    run = 1'b0; report_in = 4'h2;
    tick();
    report_in = 4'h0;
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL %s_restart_level: got %0d want 1", tag, fifo_level); end
    checks++; if (rpt_if.rpt_data !== {32'd0, 4'h2}) begin errors++; $display("FAIL %s_restart_ts: got %h want %h", tag, rpt_if.rpt_data, {32'd0, 4'h2}); end
    rpt_if.rpt_ready = 1'b1;
    tick();
    rpt_if.rpt_ready = 1'b0;
  endtask

  task automatic test_clear_mid();
    queue_three();
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL clr_pre_level: got %0d want 3", fifo_level); end
    clear = 1'b1; run = 1'b1; report_in = 4'h2; rpt_if.rpt_ready = 1'b1;
    tick();
    clear = 1'b0; run = 1'b0; report_in = 4'h0; rpt_if.rpt_ready = 1'b0;
    checks++; if (rpt_if.rpt_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", rpt_if.rpt_valid); end
    checks++; if ({fifo_level, overflow, drop_count, any_report} !== 22'h0) begin errors++; $display("FAIL clr_flags: level=%0d ovf=%b drop=%0d any=%b want 0", fifo_level, overflow, drop_count, any_report); end
    check_restart("clr");
  endtask

  task automatic test_reset_mid();
    queue_three();
    checks++; if ({fifo_level, any_report} !== {4'd3, 1'b1}) begin errors++; $display("FAIL rst_pre: level=%0d any=%b want 3 1", fifo_level, any_report); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({rpt_if.rpt_valid, rpt_if.rpt_data} !== 37'h0) begin errors++; $display("FAIL rst_async_out: valid=%b data=%h want 0", rpt_if.rpt_valid, rpt_if.rpt_data); end
    checks++; if ({fifo_level, overflow, drop_count, any_report} !== 22'h0) begin errors++; $display("FAIL rst_async_flags: level=%0d ovf=%b drop=%0d any=%b want 0", fifo_level, overflow, drop_count, any_report); end
    #1;
    reset = 1'b0;
    check_restart("rst");
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_gap();
    test_overflow();
    test_full_push_pop();
    test_wrap_saturation();
    test_clear_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ltl_report_collector.md
# ltl_report_collector

Downstream capture stage for the rule-monitor automata (one instance per cluster automaton). Samples the automaton's report-STE `active_state` vector after every consumed symbol and tags each non-zero vector with the index of the symbol that triggered it. Buffers the tagged events in a FIFO and presents them to the monitor aggregator over a valid/ready handshake. Keeps sticky overflow and "any report" status plus a saturating drop counter for the host.

## Interface

Parameters:
- `NUM_REPORTS`, default 4: number of report STE outputs. Bit order is the automaton's report-port declaration order, first port at bit 0.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.
- `TS_WIDTH`, default 32: symbol-index timestamp width.
- `CNT_WIDTH`, default 16: drop counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear of all state except configuration; highest priority.
- `run` in 1: the same `run` driven to the automaton; high means a symbol is consumed this cycle.
- `report_in` in NUM_REPORTS: report-STE `active_state` outputs.
- `rpt_valid` out 1: FIFO head entry is valid.
- `rpt_ready` in 1: consumer accepts the head entry.
- `rpt_data` out TS_WIDTH+NUM_REPORTS: `{timestamp, report_mask}`.
- `fifo_level` out $clog2(DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky; at least one event was dropped.
- `drop_count` out CNT_WIDTH: count of dropped events, saturating.
- `any_report` out 1: sticky OR of all pushed or dropped events.

## Operation

- **Symbol index counter `sym_idx`.**
  - Resets/clears to 0.
  - Increments by 1 on every cycle with `run`=1.
  - Wraps modulo 2^TS_WIDTH with no flag.
- **Alignment stage.** The STEs register on the edge at which `run` is sampled, so `report_in` reflects symbol N in the cycle after N is consumed. On each edge the block registers:
  - `run_q` ← `run`
  - `ts_q` ← `sym_idx` (the value before the increment)
- **Event.** An event occurs in a cycle where `run_q`=1 and `report_in` ≠ 0.
  - Entry pushed: `{ts_q, report_in}`.
  - `report_in` is ignored whenever `run_q`=0.
- **FIFO.**
  - Circular buffer with read/write pointers one bit wider than the address. Full = MSBs differ and the address bits are equal.
  - Pop occurs when `rpt_valid` and `rpt_ready` are both 1.
  - Push when full and no pop in the same cycle: the entry is dropped, `overflow` is set, `drop_count` increments, saturating at all-ones.
  - Push when full with a pop in the same cycle: the push is accepted and the level stays at DEPTH.
  - Push and pop in the same cycle when not full: both occur and the level is unchanged.
  - No same-cycle bypass. An event pushed into an empty FIFO appears on `rpt_valid` the next cycle.
  - `rpt_data` is held stable while `rpt_valid`=1 and `rpt_ready`=0.
  - `rpt_data` reads as all-zeros whenever `rpt_valid`=0.
- **`any_report`.** Set on any event, whether pushed or dropped. Cleared only by `reset` or `clear`.
- **`clear`.** Effects in the cycle it is asserted:
  - Empties the FIFO and zeros `sym_idx`, `run_q`, `ts_q`, `overflow`, `drop_count` and `any_report`.
  - An event or pop in the same cycle is discarded.
  - A `run` in the same cycle does not count.
- **Reset values** (all outputs): `rpt_valid`=0, `rpt_data`=0, `fifo_level`=0, `overflow`=0, `drop_count`=0, `any_report`=0.

## Timing

- Latency from the `run` cycle consuming symbol N to that event on `rpt_valid`: 2 cycles (alignment, then FIFO write), provided the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Flag timing:
  - `fifo_level`, `overflow`, `drop_count` and `any_report` update on the edge that performs the push, drop or pop.
  - All are registered outputs, so they are visible the following cycle.
- `rpt_ready` may toggle freely. `rpt_valid` does not depend combinationally on `rpt_ready`.
- Reset asserted mid-stream: all state is zeroed immediately and asynchronously. The first symbol after deassertion has index 0.

## Test plan

- **Single event.** Reset, then `run`=1 for symbols 0..5, with `report_in`=4'b0010 in the cycle after symbol 3 → one entry `{32'd3, 4'b0010}` with `rpt_valid` rising 2 cycles after symbol 3. Then `any_report`=1, `fifo_level` 1→0 after the pop.
- **Gap handling.** `run` toggles 1,0,1 with `report_in`=4'b1111 held constantly → exactly 2 entries, timestamps 0 and 1. No entry for the `run_q`=0 cycle.
- **Overflow.** `rpt_ready`=0, 10 consecutive events → `fifo_level`=8, `overflow`=1, `drop_count`=2. The stored entries hold timestamps 0..7 in order.
- **Full with simultaneous push/pop.** Full FIFO, event plus `rpt_ready`=1 in the same cycle → no drop, `fifo_level` stays 8, the new entry lands at the tail.
- **Wrap and saturation.** With `TS_WIDTH`=4 and `CNT_WIDTH`=2:
  - Symbol 17 reports timestamp 1.
  - 5 drops leave `drop_count`=3.
- **Clear and reset mid-operation.**
  - `clear` during a push with 3 entries queued → next cycle `rpt_valid`=0, all flags are 0, and the next symbol has index 0.
  - Repeat with async `reset` asserted mid-cycle → same result with no clock edge needed.
